// File: rtl/bus_command_gen.sv
// CPU bus command generator: turns raw CPU status (ALE/RD_N/WR_N/IO_OR_M/DT_OR_R)
// into registered memory/I-O command strobes, with I/O recovery spacing.
module bus_command_gen #(
   parameter int RECOVERY_CYCLES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic cpu_clock_posedge,
   input  logic cpu_clock_negedge,
   input  logic HLDA,
   input  logic ALE,
   input  logic RD_N,
   input  logic WR_N,
   input  logic IO_OR_M,
   input  logic DT_OR_R,
   output logic X_IO_OR_M,
   output logic R_OR_DT,
   output logic MEMR_N,
   output logic MEMW_N,
   output logic IOR_N,
   output logic IOW_N,
   output logic IO_E
);

   typedef enum logic [1:0] {IDLE, ADDR, CMD, RECOV} state_t;

   localparam logic [3:0] RECOV_LOAD = 4'(RECOVERY_CYCLES);

   state_t     state;
   state_t     state_next;
   logic [3:0] recov_cnt;
   logic       ale_hit;
   logic       cmd_req;
   logic       cmd_done;
   logic       latch;
   logic       hold;
   logic       io_cmd_end;

   // Only the strobe matching the latched direction counts, so RD_N/WR_N both low is safe.
   assign cmd_req  = R_OR_DT ? ~RD_N : ~WR_N;
   assign cmd_done = R_OR_DT ? RD_N : WR_N;

   // From IDLE a cycle only starts on a CPU falling edge; once busy, ALE restarts the cycle at once.
   assign ale_hit  = ALE && ((state != IDLE) || cpu_clock_negedge);

   always_comb begin
      state_next = state;
      latch      = 1'b0;
      if (HLDA) begin
         state_next = IDLE;
      end else if (ale_hit) begin
         state_next = ADDR;
         latch      = 1'b1;
      end else begin
         case (state)
            ADDR: begin
               if (cpu_clock_posedge) begin
                  if (X_IO_OR_M && (recov_cnt != 4'd0)) begin
                     state_next = RECOV;
                  end else if (cmd_req) begin
                     state_next = CMD;
                  end
               end
            end
            RECOV: begin
               if (cpu_clock_posedge && (recov_cnt <= 4'd1) && cmd_req) begin
                  state_next = CMD;
               end
            end
            CMD: begin
               if (cpu_clock_negedge && cmd_done) begin
                  state_next = IDLE;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Strobes assert one clock after entering CMD and release on the clock that leaves it.
   assign hold       = (state == CMD) && (state_next == CMD);
   assign io_cmd_end = (state == CMD) && (state_next != CMD) && X_IO_OR_M;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         X_IO_OR_M <= 1'b0;
         R_OR_DT   <= 1'b1;
         MEMR_N    <= 1'b1;
         MEMW_N    <= 1'b1;
         IOR_N     <= 1'b1;
         IOW_N     <= 1'b1;
         recov_cnt <= 4'd0;
      end else begin
         state <= state_next;
         if (latch) begin
            X_IO_OR_M <= IO_OR_M;
            R_OR_DT   <= ~DT_OR_R;
         end
         MEMR_N <= ~(hold && !X_IO_OR_M &&  R_OR_DT);
         MEMW_N <= ~(hold && !X_IO_OR_M && !R_OR_DT);
         IOR_N  <= ~(hold &&  X_IO_OR_M &&  R_OR_DT);
         IOW_N  <= ~(hold &&  X_IO_OR_M && !R_OR_DT);
         // Counting continues through HLDA; a freshly finished I/O command reloads it.
         if (io_cmd_end) begin
            recov_cnt <= RECOV_LOAD;
         end else if (cpu_clock_posedge && (recov_cnt != 4'd0)) begin
            recov_cnt <= recov_cnt - 4'd1;
         end
      end
   end

   assign IO_E = ((state == CMD) && X_IO_OR_M) || (state == RECOV);

endmodule

// File: tb/tb_bus_command_gen.sv
// Directed bench for bus_command_gen: one instance with recovery 2, one with recovery 0,
// driven in lockstep; output vector is {X_IO_OR_M,R_OR_DT,MEMR_N,MEMW_N,IOR_N,IOW_N,IO_E}.
module tb_bus_command_gen;

   logic clock = 1'b0;
   logic reset, cpu_clock_posedge, cpu_clock_negedge, HLDA, ALE, RD_N, WR_N, IO_OR_M, DT_OR_R;
   logic x_a, r_a, memr_a, memw_a, ior_a, iow_a, ioe_a;
   logic x_b, r_b, memr_b, memw_b, ior_b, iow_b, ioe_b;
   logic [6:0] out_a, out_b;
   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   bus_command_gen #(.RECOVERY_CYCLES(2)) dut (
      .clock(clock), .reset(reset),
      .cpu_clock_posedge(cpu_clock_posedge), .cpu_clock_negedge(cpu_clock_negedge),
      .HLDA(HLDA), .ALE(ALE), .RD_N(RD_N), .WR_N(WR_N), .IO_OR_M(IO_OR_M), .DT_OR_R(DT_OR_R),
      .X_IO_OR_M(x_a), .R_OR_DT(r_a), .MEMR_N(memr_a), .MEMW_N(memw_a),
      .IOR_N(ior_a), .IOW_N(iow_a), .IO_E(ioe_a)
   );

   bus_command_gen #(.RECOVERY_CYCLES(0)) dut0 (
      .clock(clock), .reset(reset),
      .cpu_clock_posedge(cpu_clock_posedge), .cpu_clock_negedge(cpu_clock_negedge),
      .HLDA(HLDA), .ALE(ALE), .RD_N(RD_N), .WR_N(WR_N), .IO_OR_M(IO_OR_M), .DT_OR_R(DT_OR_R),
      .X_IO_OR_M(x_b), .R_OR_DT(r_b), .MEMR_N(memr_b), .MEMW_N(memw_b),
      .IOR_N(ior_b), .IOW_N(iow_b), .IO_E(ioe_b)
   );

   assign out_a = {x_a, r_a, memr_a, memw_a, ior_a, iow_a, ioe_a};
   assign out_b = {x_b, r_b, memr_b, memw_b, ior_b, iow_b, ioe_b};

   task automatic tick(input logic pe, input logic ne);
      cpu_clock_posedge = pe;
      cpu_clock_negedge = ne;
      @(posedge clock);
      #1;
      cpu_clock_posedge = 1'b0;
      cpu_clock_negedge = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b required %b", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; cpu_clock_posedge = 1'b0; cpu_clock_negedge = 1'b0; HLDA = 1'b0;
      ALE = 1'b0; RD_N = 1'b1; WR_N = 1'b1; IO_OR_M = 1'b0; DT_OR_R = 1'b0;
      tick(0, 0);
      tick(0, 0);
      reset = 1'b0;
      chk("reset_a", out_a, 7'b0_1_1111_0);
      chk("reset_b", out_b, 7'b0_1_1111_0);

      // memory read
      ALE = 1'b1; IO_OR_M = 1'b0; DT_OR_R = 1'b0;
      tick(0, 1);
      chk("mr_addr", out_a, 7'b0_1_1111_0);
      ALE = 1'b0; RD_N = 1'b0;
      tick(1, 0);
      chk("mr_cmd_edge", out_a, 7'b0_1_1111_0);
      tick(0, 0);
      chk("mr_memr_low", out_a, 7'b0_1_0111_0);
      tick(0, 1);
      chk("mr_hold_rd0", out_a, 7'b0_1_0111_0);
      RD_N = 1'b1;
      tick(0, 1);
      chk("mr_end", out_a, 7'b0_1_1111_0);

      // memory write with RD_N and WR_N both low, then reset mid-command
      ALE = 1'b1; IO_OR_M = 1'b0; DT_OR_R = 1'b1;
      tick(0, 1);
      chk("mw_addr", out_a, 7'b0_0_1111_0);
      ALE = 1'b0; RD_N = 1'b0; WR_N = 1'b0;
      tick(1, 0);
      tick(0, 0);
      chk("mw_only_memw", out_a, 7'b0_0_1011_0);
      reset = 1'b1;
      tick(1, 1);
      reset = 1'b0; RD_N = 1'b1; WR_N = 1'b1;
      chk("mw_reset", out_a, 7'b0_1_1111_0);

      // ALE beats a qualifying posedge on the same clock
      ALE = 1'b1; IO_OR_M = 1'b0; DT_OR_R = 1'b0;
      tick(0, 1);
      RD_N = 1'b0;
      tick(1, 0);
      tick(0, 0);
      chk("ale_wins", out_a, 7'b0_1_1111_0);
      ALE = 1'b0;
      tick(1, 0);
      tick(0, 0);
      chk("ale_then_cmd", out_a, 7'b0_1_0111_0);
      RD_N = 1'b1;
      tick(0, 1);

      // back-to-back I/O writes
      ALE = 1'b1; IO_OR_M = 1'b1; DT_OR_R = 1'b1;
      tick(0, 1);
      chk("iow1_addr", out_a, 7'b1_0_1111_0);
      ALE = 1'b0; WR_N = 1'b0;
      tick(1, 0);
      chk("iow1_cmd_ioe", out_a, 7'b1_0_1111_1);
      tick(0, 0);
      chk("iow1_low", out_a, 7'b1_0_1110_1);
      WR_N = 1'b1;
      tick(0, 1);
      chk("iow1_end", out_a, 7'b1_0_1111_0);
      tick(1, 0);
      ALE = 1'b1;
      tick(0, 1);
      ALE = 1'b0; WR_N = 1'b0;
      tick(1, 0);
      chk("iow2_recov", out_a, 7'b1_0_1111_1);
      chk("iow2_norecov_cmd", out_b, 7'b1_0_1111_1);
      tick(0, 0);
      chk("iow2_recov_hold", out_a, 7'b1_0_1111_1);
      chk("iow2_norecov_low", out_b, 7'b1_0_1110_1);
      tick(0, 1);
      chk("iow2_recov_neg", out_a, 7'b1_0_1111_1);
      tick(1, 0);
      chk("iow2_cmd", out_a, 7'b1_0_1111_1);
      tick(0, 0);
      chk("iow2_low", out_a, 7'b1_0_1110_1);
      WR_N = 1'b1;
      tick(0, 1);
      chk("iow2_end", out_a, 7'b1_0_1111_0);

      // I/O read interrupted by HLDA
      tick(1, 0);
      tick(1, 0);
      ALE = 1'b1; IO_OR_M = 1'b1; DT_OR_R = 1'b0;
      tick(0, 1);
      ALE = 1'b0; RD_N = 1'b0;
      tick(1, 0);
      tick(0, 0);
      chk("ior_low", out_a, 7'b1_1_1101_1);
      chk("ior_low_b", out_b, 7'b1_1_1101_1);
      HLDA = 1'b1;
      tick(0, 0);
      chk("hlda_release", out_a, 7'b1_1_1111_0);
      ALE = 1'b1;
      tick(0, 1);
      chk("hlda_blocks_ale", out_a, 7'b1_1_1111_0);
      HLDA = 1'b0; ALE = 1'b0;
      tick(1, 0);
      tick(0, 0);
      chk("hlda_stay_idle", out_a, 7'b1_1_1111_0);

      // consecutive I/O reads: recovery 2 vs recovery 0
      RD_N = 1'b1;
      ALE = 1'b1;
      tick(0, 1);
      ALE = 1'b0; RD_N = 1'b0;
      tick(1, 0);
      chk("ior2_recov", out_a, 7'b1_1_1111_1);
      chk("ior2_b_cmd", out_b, 7'b1_1_1111_1);
      tick(0, 0);
      chk("ior2_b_low", out_b, 7'b1_1_1101_1);
      RD_N = 1'b1;
      tick(0, 1);
      chk("ior2_b_end", out_b, 7'b1_1_1111_0);
      ALE = 1'b1;
      tick(0, 1);
      ALE = 1'b0; RD_N = 1'b0;
      tick(1, 0);
      tick(0, 0);
      chk("ior3_a_low", out_a, 7'b1_1_1101_1);
      chk("ior3_b_low", out_b, 7'b1_1_1101_1);
      RD_N = 1'b1;
      tick(0, 1);
      chk("ior3_end", out_a, 7'b1_1_1111_0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bus_command_gen.md
BUS_COMMAND_GEN -- requirements
Module: bus_command_gen

Interface
REQ-001 Parameter RECOVERY_CYCLES, default 2: minimum CPU clocks (cpu_clock_posedge counts) between the end of one I/O command and the start of the next; range 0..15.
REQ-002 clock  in  1  system clock; the only clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cpu_clock_posedge / cpu_clock_negedge  in  1 each  single-clock enables marking CPU clock edges.
REQ-005 HLDA  in  1  CPU hold acknowledge; high = bus granted away.
REQ-006 ALE, RD_N, WR_N, IO_OR_M, DT_OR_R  in  1 each  raw CPU bus status; IO_OR_M 1 = I/O; DT_OR_R 1 = CPU transmit (write).
REQ-007 X_IO_OR_M  out  1  latched I/O-or-memory status for the current cycle.
REQ-008 R_OR_DT  out  1  latched direction; 1 = read cycle.
REQ-009 MEMR_N, MEMW_N, IOR_N, IOW_N  out  1 each  active-low command strobes.
REQ-010 IO_E  out  1  high while an I/O command strobe is asserted, or held off by recovery.

Function
REQ-011 States: IDLE, ADDR, CMD, RECOV; state changes occur only on clock edges qualified as stated below.
REQ-012 IDLE->ADDR on cpu_clock_negedge with ALE=1 and HLDA=0; same edge latches X_IO_OR_M<=IO_OR_M and R_OR_DT<=~DT_OR_R.
REQ-013 X_IO_OR_M and R_OR_DT hold from latch until the next latch or reset; ALE while not IDLE re-latches and returns to ADDR (the current command is deasserted on that clock).
REQ-014 ADDR->CMD on cpu_clock_posedge when (RD_N=0 and R_OR_DT=1) or (WR_N=0 and R_OR_DT=0), unless X_IO_OR_M=1 and recovery count is nonzero.
REQ-015 In CMD exactly one strobe is low: X_IO_OR_M/R_OR_DT select IOR_N, IOW_N, MEMR_N or MEMW_N; all others high.
REQ-016 Strobe goes low on the clock after the qualifying ADDR->CMD edge (one-clock registered latency) and stays low while in CMD.
REQ-017 CMD->IDLE on cpu_clock_negedge when the sampled matching RD_N/WR_N is 1; the strobe is high on the following clock.
REQ-018 On leaving CMD for an I/O cycle, recovery counter loads RECOVERY_CYCLES; it decrements on each cpu_clock_posedge, saturating at 0; RECOVERY_CYCLES=0 disables it.
REQ-019 An I/O cycle reaching ADDR while counter>0 enters RECOV; RECOV->CMD on the cpu_clock_posedge where counter is 1 or 0 and RD_N/WR_N still qualify; memory cycles ignore the counter.
REQ-020 IO_E = 1 in CMD with X_IO_OR_M=1, and in RECOV; else 0.
REQ-021 HLDA=1 forces IDLE on the next clock from any state: all strobes high, IO_E=0; recovery counter keeps counting.
REQ-022 ALE and a qualifying cpu_clock_posedge on the same clock: ALE wins.
REQ-023 Simultaneous RD_N=0 and WR_N=0: only the one matching R_OR_DT is honoured.

Reset
REQ-024 Reset: state IDLE, MEMR_N=MEMW_N=IOR_N=IOW_N=1, IO_E=0, X_IO_OR_M=0, R_OR_DT=1, recovery counter 0.
REQ-025 Reset asserted mid-command deasserts all strobes on the next clock and overrides every other input.

Verification
REQ-026 Memory read: ALE=1,IO_OR_M=0,DT_OR_R=0 at negedge, RD_N=0 at next posedge -> MEMR_N low 1 clock later, held until RD_N=1 sampled at negedge; IO_E stays 0.
REQ-027 Back-to-back I/O writes, RECOVERY_CYCLES=2: second IOW_N assertion delayed until 2 cpu_clock_posedges after the first ends; IO_E=1 throughout RECOV.
REQ-028 HLDA raised while IOR_N low -> IOR_N=1, IO_E=0 next clock; state IDLE; no strobe until new ALE with HLDA=0.
REQ-029 RD_N=0 and WR_N=0 together in a write cycle (DT_OR_R=1) -> only MEMW_N low; MEMR_N stays 1.
REQ-030 Reset pulsed during MEMW_N low -> all strobes 1, X_IO_OR_M=0, R_OR_DT=1 one clock after reset.
REQ-031 RECOVERY_CYCLES=0, consecutive I/O reads -> no RECOV state; IOR_N latency identical to memory reads.
